// File: rtl/instr_retire_trace.sv
// Retire tracer for the multi-cycle ARM core.
// Follows the main-FSM state and the core/memory bus, builds one record per
// completed instruction and queues it in a first-word-fall-through FIFO that a
// valid/ready consumer drains. A record is committed at the FETCH that starts
// the next instruction.
module instr_retire_trace #(
  parameter int DEPTH = 16,
  parameter int CYC_W = 8,
  parameter int OVF_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [3:0]               state,
  input  logic [31:0]              PC,
  input  logic [31:0]              Instr,
  input  logic [31:0]              Adr,
  input  logic [31:0]              WriteData,
  input  logic                     MemWrite,
  output logic                     tr_valid,
  input  logic                     tr_ready,
  output logic [31:0]              tr_pc,
  output logic [31:0]              tr_instr,
  output logic [CYC_W-1:0]         tr_cycles,
  output logic                     tr_store,
  output logic [31:0]              tr_adr,
  output logic [31:0]              tr_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [OVF_W-1:0]         overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0]  ST_FETCH  = 4'd0;
  localparam logic [3:0]  ST_DECODE = 4'd1;
  localparam logic [3:0]  ST_MEMWR  = 4'd5;
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);

  // Tracking state for the instruction currently in flight
  logic              r_in_flight;
  logic [31:0]       r_cur_pc;
  logic [31:0]       r_cur_instr;
  logic [CYC_W-1:0]  r_cyc;
  logic              r_store;
  logic [31:0]       r_adr;
  logic [31:0]       r_wdata;

  // FIFO storage, one array per record field
  logic [31:0]       r_mem_pc    [DEPTH];
  logic [31:0]       r_mem_instr [DEPTH];
  logic [CYC_W-1:0]  r_mem_cyc   [DEPTH];
  logic              r_mem_store [DEPTH];
  logic [31:0]       r_mem_adr   [DEPTH];
  logic [31:0]       r_mem_wdata [DEPTH];

  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic [OVF_W-1:0]  r_ovf;

  logic w_commit;
  logic w_push;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_wr;

  // A commit happens on the FETCH that follows a tracked instruction; the
  // pop is qualified by the registered occupancy, so tr_ready never reaches tr_valid.
  assign w_commit = (state == ST_FETCH) && r_in_flight;
  assign w_push   = w_commit && enable;
  assign w_valid  = (r_count != {(AW+1){1'b0}});
  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = tr_ready && w_valid;
  assign w_wr     = w_push && (!w_full || w_pop);

  // Capture PC/IR/store info and count cycles of the in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_flight <= 1'b0;
      r_cur_pc    <= 32'd0;
      r_cur_instr <= 32'd0;
      r_cyc       <= {CYC_W{1'b0}};
      r_store     <= 1'b0;
      r_adr       <= 32'd0;
      r_wdata     <= 32'd0;
    end else if (state == ST_FETCH) begin
      r_in_flight <= 1'b1;
      r_cur_pc    <= PC;
      r_cyc       <= CYC_W'(1);
      r_store     <= 1'b0;
      r_adr       <= 32'd0;
      r_wdata     <= 32'd0;
    end else begin
      if (r_cyc != {CYC_W{1'b1}}) begin
        r_cyc <= r_cyc + CYC_W'(1);
      end
      // IR was loaded at the FETCH edge, so it is stable during DECODE
      if (state == ST_DECODE) begin
        r_cur_instr <= Instr;
      end
      if ((state == ST_MEMWR) && MemWrite) begin
        r_store <= 1'b1;
        r_adr   <= Adr;
        r_wdata <= WriteData;
      end
    end
  end

  // Write the record held before this edge into the tail slot
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_pc[r_wptr]    <= r_cur_pc;
      r_mem_instr[r_wptr] <= r_cur_instr;
      r_mem_cyc[r_wptr]   <= r_cyc;
      r_mem_store[r_wptr] <= r_store;
      r_mem_adr[r_wptr]   <= r_adr;
      r_mem_wdata[r_wptr] <= r_wdata;
    end
  end

  // Pointer, occupancy and dropped-record bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
      r_ovf   <= {OVF_W{1'b0}};
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // Newest record is dropped when full and nothing leaves on this edge
      if (w_push && w_full && !w_pop && (r_ovf != {OVF_W{1'b1}})) begin
        r_ovf <= r_ovf + OVF_W'(1);
      end
    end
  end

  // Present the head entry; fields read as zero while the FIFO is empty
  always_comb begin
    tr_valid     = w_valid;
    count        = r_count;
    overflow_cnt = r_ovf;
    if (w_valid) begin
      tr_pc     = r_mem_pc[r_rptr];
      tr_instr  = r_mem_instr[r_rptr];
      tr_cycles = r_mem_cyc[r_rptr];
      tr_store  = r_mem_store[r_rptr];
      tr_adr    = r_mem_adr[r_rptr];
      tr_wdata  = r_mem_wdata[r_rptr];
    end else begin
      tr_pc     = 32'd0;
      tr_instr  = 32'd0;
      tr_cycles = {CYC_W{1'b0}};
      tr_store  = 1'b0;
      tr_adr    = 32'd0;
      tr_wdata  = 32'd0;
    end
  end

endmodule

// File: tb/tb_instr_retire_trace.sv
// Self-checking bench for instr_retire_trace: instruction-level reference
// model (record per instruction, queue for the FIFO) plus directed scenarios.
module tb_instr_retire_trace;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  cyc;
    logic        store;
    logic [31:0] adr;
    logic [31:0] wdata;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset, enable, MemWrite, tr_valid, tr_ready, tr_store;
  logic [3:0]  state;
  logic [31:0] PC, Instr, Adr, WriteData, tr_pc, tr_instr, tr_adr, tr_wdata;
  logic [7:0]  tr_cycles;
  logic [4:0]  count;
  logic [15:0] overflow_cnt;

  instr_retire_trace #(.DEPTH(16), .CYC_W(8), .OVF_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .state(state), .PC(PC),
    .Instr(Instr), .Adr(Adr), .WriteData(WriteData), .MemWrite(MemWrite),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_instr(tr_instr),
    .tr_cycles(tr_cycles), .tr_store(tr_store), .tr_adr(tr_adr), .tr_wdata(tr_wdata),
    .count(count), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  // reference model
  rec_t        q[$];
  rec_t        popped[$];
  rec_t        m_pending, m_next;
  bit          m_in_flight;
  int          m_ovf;
  int          g_rmode;   // 0 never ready, 1 always, 2 random, 3 only on FETCH
  bit          g_en;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", {63'd0, tr_valid}, {63'd0, q.size() != 0});
    chk("count", {59'd0, count}, 64'(q.size()));
    chk("overflow_cnt", {48'd0, overflow_cnt}, 64'(m_ovf));
    if (q.size() != 0) begin
      chk("tr_pc", {32'd0, tr_pc}, {32'd0, q[0].pc});
      chk("tr_instr", {32'd0, tr_instr}, {32'd0, q[0].instr});
      chk("tr_cycles", {56'd0, tr_cycles}, {56'd0, q[0].cyc});
      chk("tr_store", {63'd0, tr_store}, {63'd0, q[0].store});
      chk("tr_adr", {32'd0, tr_adr}, {32'd0, q[0].adr});
      chk("tr_wdata", {32'd0, tr_wdata}, {32'd0, q[0].wdata});
    end
  endtask

  // one clock: drive, advance model, check
  task automatic step(input logic [3:0] st, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] a, input logic [31:0] wd, input logic mw);
    logic rdy;
    bit   pop, commit;
    rec_t rec;
    case (g_rmode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = (st == 4'd0);
    endcase
    reset = 1'b0; enable = g_en; state = st; PC = pc; Instr = ins;
    Adr = a; WriteData = wd; MemWrite = mw; tr_ready = rdy;
    if (rdy && tr_valid)
      popped.push_back('{tr_pc, tr_instr, tr_cycles, tr_store, tr_adr, tr_wdata});
    @(posedge clk);
    pop = rdy && (q.size() != 0);
    commit = 1'b0;
    if (st == 4'd0) begin
      commit = m_in_flight;
      rec = m_pending;
      m_pending = m_next;
      m_in_flight = 1'b1;
    end
    if (pop) void'(q.pop_front());
    if (commit && g_en) begin
      if (q.size() < DEPTH) q.push_back(rec);
      else if (m_ovf != 65535) m_ovf++;
    end
    #1;
    check_outputs();
  endtask

  // extra non-FETCH cycles of the in-flight instruction
  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_pending.cyc != 8'hFF) m_pending.cyc = m_pending.cyc + 8'd1;
      step(4'd10, $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  // kind: 0 ADD imm, 1 STR, 2 LDR, 3 B, 4 DP reg, 5 unknown states
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] ins, input int kind,
                           input logic [31:0] a, input logic [31:0] wd);
    int seq[$];
    case (kind)
      0:       seq = '{0, 1, 7, 8};
      1:       seq = '{0, 1, 2, 5};
      2:       seq = '{0, 1, 2, 3, 4};
      3:       seq = '{0, 1, 9};
      4:       seq = '{0, 1, 6, 8};
      default: seq = '{0, 1, 11, 14};
    endcase
    m_next = '{pc, ins, 8'(seq.size()), kind == 1, (kind == 1) ? a : 32'd0,
               (kind == 1) ? wd : 32'd0};
    foreach (seq[i]) begin
      if (seq[i] == 5)
        step(4'd5, $urandom, $urandom, a, wd, 1'b1);
      else
        step(4'(seq[i]), (i == 0) ? pc : $urandom, (seq[i] == 1) ? ins : $urandom,
             $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic do_reset(input logic [3:0] st);
    reset = 1'b1; state = st; enable = 1'b1; tr_ready = 1'($urandom_range(0, 1));
    PC = $urandom; Instr = $urandom; Adr = $urandom; WriteData = $urandom;
    MemWrite = 1'b1;
    @(posedge clk);
    q.delete(); m_ovf = 0; m_in_flight = 1'b0;
    #1;
    chk("rst_valid", {63'd0, tr_valid}, 64'd0);
    chk("rst_count", {59'd0, count}, 64'd0);
    chk("rst_ovf", {48'd0, overflow_cnt}, 64'd0);
    chk("rst_fields", {tr_pc, tr_instr} | {tr_adr, tr_wdata} | {55'd0, tr_cycles, tr_store}, 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; state = 4'd0; PC = 32'd0; Instr = 32'd0;
    Adr = 32'd0; WriteData = 32'd0; MemWrite = 1'b0; tr_ready = 1'b0;
    g_en = 1'b1; g_rmode = 0; m_ovf = 0; m_in_flight = 1'b0;
    do_reset(4'd0);
    do_reset(4'd3);

    // ADD, STR, LDR, B then drain
    run_instr(32'h0, 32'hE2802005, 0, 32'h0, 32'h0);
    run_instr(32'h4, 32'hE5801008, 1, 32'h8, 32'h2A);
    run_instr(32'h8, 32'hE5902000, 2, 32'h0, 32'h0);
    run_instr(32'hC, 32'hEA000000, 3, 32'h0, 32'h0);
    run_instr(32'h10, 32'hE2802005, 0, 32'h0, 32'h0);
    popped.delete(); g_rmode = 1;
    stall(6);
    chk("t1_nrec", 64'(popped.size()), 64'd4);
    if (popped.size() == 4) begin
      chk("t1_add", {popped[0].pc, popped[0].instr}, {32'h0, 32'hE2802005});
      chk("t1_add_cyc", {55'd0, popped[0].cyc, popped[0].store}, {55'd0, 8'd4, 1'b0});
      chk("t2_str_cyc", {55'd0, popped[1].cyc, popped[1].store}, {55'd0, 8'd4, 1'b1});
      chk("t2_str_bus", {popped[1].adr, popped[1].wdata}, {32'h8, 32'h2A});
      chk("t3_ldr_cyc", {56'd0, popped[2].cyc}, 64'd5);
      chk("t3_b_cyc", {56'd0, popped[3].cyc}, 64'd3);
    end

    // overflow: 20 committed ADDs with consumer stalled
    do_reset(4'd0);
    g_rmode = 0;
    for (int i = 0; i <= 20; i++) run_instr(32'(i * 4), 32'hE2802005, 0, 32'h0, 32'h0);
    chk("t4_count", {59'd0, count}, 64'd16);
    chk("t4_ovf", {48'd0, overflow_cnt}, 64'd4);
    popped.delete(); g_rmode = 1;
    stall(20);
    chk("t4_nrec", 64'(popped.size()), 64'd16);
    foreach (popped[i]) chk("t4_order", {32'd0, popped[i].pc}, 64'(i * 4));

    // full with simultaneous push/pop, then enable=0
    g_rmode = 0;
    for (int i = 0; i < 16; i++) run_instr(32'h100 + 32'(i * 4), $urandom, 4, 32'h0, 32'h0);
    chk("t5_full", {59'd0, count}, 64'd16);
    g_rmode = 3;
    for (int i = 0; i < 4; i++) run_instr(32'h200 + 32'(i * 4), $urandom, 3, 32'h0, 32'h0);
    chk("t5_pushpop_count", {59'd0, count}, 64'd16);
    chk("t5_pushpop_ovf", {48'd0, overflow_cnt}, 64'd4);
    g_rmode = 0; g_en = 1'b0;
    for (int i = 0; i < 3; i++) run_instr(32'h300 + 32'(i * 4), $urandom, 0, 32'h0, 32'h0);
    chk("t5_dis_count", {59'd0, count}, 64'd16);
    chk("t5_dis_ovf", {48'd0, overflow_cnt}, 64'd4);
    g_en = 1'b1;

    // reset while in MEMWR with 3 records queued
    do_reset(4'd0);
    for (int i = 0; i < 3; i++) run_instr(32'(i * 4), 32'hE2802005, 0, 32'h0, 32'h0);
    m_next = '{32'hC, 32'hE5801008, 8'd4, 1'b1, 32'h8, 32'h2A};
    step(4'd0, 32'hC, $urandom, $urandom, $urandom, 1'b0);
    step(4'd1, $urandom, 32'hE5801008, $urandom, $urandom, 1'b0);
    step(4'd2, $urandom, $urandom, $urandom, $urandom, 1'b0);
    chk("t6_queued", {59'd0, count}, 64'd3);
    do_reset(4'd5);
    run_instr(32'h40, 32'hE2802005, 0, 32'h0, 32'h0);
    chk("t6_first_fetch", {59'd0, count}, 64'd0);
    run_instr(32'h44, 32'hE2802005, 0, 32'h0, 32'h0);
    chk("t6_next_fetch", {59'd0, count}, 64'd1);

    // cycle counter saturation
    g_rmode = 1;
    stall(300);
    g_rmode = 0;
    run_instr(32'h48, 32'hE2802005, 0, 32'h0, 32'h0);
    chk("sat_count", {59'd0, count}, 64'd1);
    chk("sat_cycles", {56'd0, tr_cycles}, 64'd255);

    // randomized traffic
    g_rmode = 2;
    for (int i = 0; i < 150; i++) begin
      g_en = ($urandom_range(0, 7) != 0);
      run_instr($urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 5), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) stall($urandom_range(1, 3));
    end
    g_en = 1'b1; g_rmode = 1;
    run_instr(32'h0, 32'hE2802005, 0, 32'h0, 32'h0);
    stall(20);
    chk("final_empty", {59'd0, count}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
